// File: rtl/lab07_sort_sched_if.sv
// lab07_sort_sched_if: requester, sort-unit and response signals shared by the scheduler (slave) and its environment (master)
interface lab07_sort_sched_if;
  logic [1:0]  req_valid;
  logic [15:0] req_data0;
  logic [15:0] req_data1;
  logic [1:0]  req_mode0;
  logic [1:0]  req_mode1;
  logic [1:0]  req_ready;
  logic        u_in_valid;
  logic [3:0]  u_in_number;
  logic [1:0]  u_mode;
  logic        u_out_valid;
  logic [6:0]  u_out_result;
  logic [1:0]  rsp_valid;
  logic [6:0]  rsp_result;
  logic        rsp_timeout;
  logic        busy;
  modport slave(
    input  req_valid, req_data0, req_data1, req_mode0, req_mode1, u_out_valid, u_out_result,
    output req_ready, u_in_valid, u_in_number, u_mode, rsp_valid, rsp_result, rsp_timeout, busy
  );
  modport master(
    output req_valid, req_data0, req_data1, req_mode0, req_mode1, u_out_valid, u_out_result,
    input  req_ready, u_in_valid, u_in_number, u_mode, rsp_valid, rsp_result, rsp_timeout, busy
  );
endinterface

// File: rtl/lab07_sort_sched.sv
// lab07_sort_sched: round-robin scheduler sharing one sort/arith unit between two requesters; ports clk, rst, bus (slave: requests in, unit stream out, responses out)
module lab07_sort_sched #(
  parameter int TIMEOUT = 127,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  lab07_sort_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [1:0] mode_q, mode_d, idx_q, idx_d;
  logic owner_q, owner_d, rr_q, rr_d, tout_q, tout_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [6:0] res_q, res_d;
  logic gnt, g;
  assign gnt = state_q == IDLE && |bus.req_valid;
  assign g = bus.req_valid == 2'b11 ? rr_q : bus.req_valid[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q <= '0;
      mode_q <= '0;
      idx_q <= '0;
      owner_q <= 1'b0;
      rr_q <= 1'b0;
      tout_q <= 1'b0;
      wcnt_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      mode_q <= mode_d;
      idx_q <= idx_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      tout_q <= tout_d;
      wcnt_q <= wcnt_d;
      res_q <= res_d;
    end
  end
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    mode_d = mode_q;
    idx_d = idx_q;
    owner_d = owner_q;
    rr_d = rr_q;
    tout_d = tout_q;
    wcnt_d = wcnt_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (gnt) begin
        state_d = ISSUE;
        data_d = g ? bus.req_data1 : bus.req_data0;
        mode_d = g ? bus.req_mode1 : bus.req_mode0;
        owner_d = g;
        rr_d = ~g;
        idx_d = '0;
      end
      ISSUE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = WAIT;
          wcnt_d = '0;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + CNT_W'(1);
        if (bus.u_out_valid) begin
          state_d = RESP;
          res_d = bus.u_out_result;
          tout_d = 1'b0;
        end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          res_d = '0;
          tout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = gnt ? (g ? 2'b10 : 2'b01) : 2'b00;
    bus.u_in_valid = state_q == ISSUE;
    bus.u_in_number = state_q == ISSUE ? data_q[{idx_q, 2'b00} +: 4] : 4'd0;
    bus.u_mode = mode_q;
    bus.rsp_valid = state_q == RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    bus.rsp_result = state_q == RESP ? res_q : 7'd0;
    bus.rsp_timeout = state_q == RESP && tout_q;
    bus.busy = state_q != IDLE;
  end
endmodule
